// File: rtl/adder16_rr_sched_if.sv
// Requester/result bundle for the shared split-adder scheduler.
// master drives req/operands and sees gnt/results; slave is the scheduler.
interface adder16_rr_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_bus;
  logic [NREQ*WIDTH-1:0] b_bus;
  logic [NREQ-1:0]       cin;
  logic [NREQ-1:0]       gnt;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic [WIDTH-1:0]      res_sum;
  logic                  res_cout;
  logic [1:0]            inflight;
  logic [NREQ-1:0]       pend_mask;

  modport master (
    output req, a_bus, b_bus, cin,
    input  gnt, res_valid, res_id, res_sum,
    input  res_cout, inflight, pend_mask
  );

  modport slave (
    input  req, a_bus, b_bus, cin,
    output gnt, res_valid, res_id, res_sum,
    output res_cout, inflight, pend_mask
  );
endinterface

// File: rtl/adder16_rr_sched.sv
// Round-robin shared two-stage split adder: low half then high half.
// Ports: clk, rst (sync, active-high), bus (slave: req/operands in, gnt/results out).
module adder16_rr_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
) (
  input logic               clk,
  input logic               rst,
  adder16_rr_sched_if.slave bus
);
  localparam int LO = WIDTH / 2;
  localparam int HI = WIDTH - LO;

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             v1_q, v1_d;
  logic             c1_q, c1_d;
  logic [LO-1:0]    s1_q, s1_d;
  logic [HI-1:0]    ah_q, ah_d;
  logic [HI-1:0]    bh_q, bh_d;
  logic [IDW-1:0]   id1_q, id1_d;
  logic             rv_q, rv_d;
  logic [IDW-1:0]   rid_q, rid_d;
  logic [WIDTH-1:0] rsum_q, rsum_d;
  logic             rcout_q, rcout_d;
  logic [1:0]       infl_q, infl_d;
  logic [NREQ-1:0]  pend_q, pend_d;

  logic             hit;
  logic [IDW-1:0]   g;
  logic [IDW:0]     idx;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] a_g, b_g;
  logic             cin_g;

  // Rotating search from ptr; idx is one bit wider so ptr+k
  // can be wrapped without a modulo.
  always_comb begin
    hit = 1'b0;
    g   = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!hit && bus.req[idx[IDW-1:0]]) begin
        hit = 1'b1;
        g   = idx[IDW-1:0];
      end
    end
    if (rst) hit = 1'b0;
  end

  always_comb begin
    gnt = '0;
    if (hit) gnt[g] = 1'b1;
  end

  assign a_g   = bus.a_bus[int'(g)*WIDTH +: WIDTH];
  assign b_g   = bus.b_bus[int'(g)*WIDTH +: WIDTH];
  assign cin_g = bus.cin[g];

  always_comb begin
    ptr_d   = ptr_q;
    v1_d    = hit;
    c1_d    = c1_q;
    s1_d    = s1_q;
    ah_d    = ah_q;
    bh_d    = bh_q;
    id1_d   = id1_q;
    rv_d    = v1_q;
    rid_d   = rid_q;
    rsum_d  = rsum_q;
    rcout_d = rcout_q;
    if (hit) begin
      ptr_d = (g == IDW'(NREQ-1)) ? '0 : g + IDW'(1);
      {c1_d, s1_d} = {1'b0, a_g[LO-1:0]}
                   + {1'b0, b_g[LO-1:0]}
                   + (LO+1)'(cin_g);
      ah_d  = a_g[WIDTH-1:LO];
      bh_d  = b_g[WIDTH-1:LO];
      id1_d = g;
    end
    if (v1_q) begin
      {rcout_d, rsum_d[WIDTH-1:LO]} = {1'b0, ah_q}
                                    + {1'b0, bh_q}
                                    + (HI+1)'(c1_q);
      rsum_d[LO-1:0] = s1_q;
      rid_d          = id1_q;
    end
    // An op counts from its grant edge until its strobe cycle ends,
    // so two ops from one requester keep its bit set throughout.
    infl_d = 2'(v1_d) + 2'(rv_d);
    pend_d = '0;
    if (v1_d) pend_d[id1_d] = 1'b1;
    if (rv_d) pend_d[id1_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      v1_q    <= 1'b0;
      c1_q    <= 1'b0;
      s1_q    <= '0;
      ah_q    <= '0;
      bh_q    <= '0;
      id1_q   <= '0;
      rv_q    <= 1'b0;
      rid_q   <= '0;
      rsum_q  <= '0;
      rcout_q <= 1'b0;
      infl_q  <= '0;
      pend_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      v1_q    <= v1_d;
      c1_q    <= c1_d;
      s1_q    <= s1_d;
      ah_q    <= ah_d;
      bh_q    <= bh_d;
      id1_q   <= id1_d;
      rv_q    <= rv_d;
      rid_q   <= rid_d;
      rsum_q  <= rsum_d;
      rcout_q <= rcout_d;
      infl_q  <= infl_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.res_valid = rv_q;
  assign bus.res_id    = rid_q;
  assign bus.res_sum   = rsum_q;
  assign bus.res_cout  = rcout_q;
  assign bus.inflight  = infl_q;
  assign bus.pend_mask = pend_q;
endmodule

// File: tb/tb_adder16_rr_sched.sv
// Scoreboard bench for adder16_rr_sched: random and directed traffic.
// Expected results are queued at grant and popped on res_valid.
module tb_adder16_rr_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;

  typedef struct {
    int          id;
    logic [15:0] sum;
    logic        cout;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  exp_t sb[$];

  logic [15:0] a_v[NREQ];
  logic [15:0] b_v[NREQ];
  logic [3:0]  cin_v;

  int ptr_m;
  int gh1;
  int gh2;

  adder16_rr_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  adder16_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      bus.a_bus[i*16 +: 16] = a_v[i];
      bus.b_bus[i*16 +: 16] = b_v[i];
    end
    bus.cin = cin_v;
  endtask

  task automatic cyc();
    apply();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req = 4'b0000;
    repeat (n) cyc();
  endtask

  task automatic rnd_ops();
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b_v[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
    end
    cin_v = 4'($urandom);
  endtask

  // Reference: rotating priority from a pointer, ops live for two cycles.
  always @(negedge clk) begin
    int          g;
    int          idx;
    logic [3:0]  eg;
    logic [3:0]  ep;
    logic [15:0] ao;
    logic [15:0] bo;
    logic [16:0] t;
    exp_t        e;
    g  = -1;
    eg = '0;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (ptr_m + k) % NREQ;
        if (g < 0 && bus.req[idx]) g = idx;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    ep = '0;
    if (gh1 >= 0) ep[gh1] = 1'b1;
    if (gh2 >= 0) ep[gh2] = 1'b1;
    check("gnt", 32'(bus.gnt), 32'(eg));
    check("inflight", 32'(bus.inflight), 32'((gh1 >= 0) + (gh2 >= 0)));
    check("pend_mask", 32'(bus.pend_mask), 32'(ep));
    check("res_valid", 32'(bus.res_valid), 32'(gh2 >= 0));
    if (g >= 0) begin
      ao     = bus.a_bus[g*16 +: 16];
      bo     = bus.b_bus[g*16 +: 16];
      t      = {1'b0, ao} + {1'b0, bo} + 17'(bus.cin[g]);
      e.id   = g;
      e.sum  = t[15:0];
      e.cout = t[16];
      sb.push_back(e);
      ptr_m = (g + 1) % NREQ;
    end
    if (rst) begin
      gh1   = -1;
      gh2   = -1;
      ptr_m = 0;
    end else begin
      gh2 = gh1;
      gh1 = g;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus.res_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_unexpected: got id %0d sum %0h expected none at %0t",
                 bus.res_id, bus.res_sum, $time);
      end else begin
        e = sb.pop_front();
        check("res_id", 32'(bus.res_id), 32'(e.id));
        check("res_sum", 32'(bus.res_sum), 32'(e.sum));
        check("res_cout", 32'(bus.res_cout), 32'(e.cout));
      end
    end
    if (rst) sb.delete();
  end

  initial begin
    errors  = 0;
    checks  = 0;
    ptr_m   = 0;
    gh1     = -1;
    gh2     = -1;
    rst     = 1'b1;
    bus.req = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    cin_v = '0;
    repeat (2) cyc();
    check("rst_sum", 32'(bus.res_sum), 32'h0);
    check("rst_id", 32'(bus.res_id), 32'h0);
    check("rst_cout", 32'(bus.res_cout), 32'h0);
    rst = 1'b0;

    bus.req = 4'b0001;
    a_v[0] = 16'h00FF; b_v[0] = 16'h0001; cin_v = 4'b0000;
    cyc();
    idle(3);

    bus.req = 4'b0010;
    a_v[1] = 16'hFFFF; b_v[1] = 16'hFFFF; cin_v = 4'b0010;
    cyc();
    a_v[1] = 16'hFF00; b_v[1] = 16'h0100; cin_v = 4'b0000;
    cyc();
    idle(3);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      rnd_ops();
      cyc();
    end
    idle(3);

    bus.req = 4'b0111;
    repeat (3) begin rnd_ops(); cyc(); end
    bus.req = 4'b1001;
    repeat (2) begin rnd_ops(); cyc(); end
    idle(3);

    bus.req = 4'b0010;
    a_v[1] = 16'h1234; b_v[1] = 16'h0F0F; cin_v = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      a_v[1] = 16'h1234 + 16'(k);
      cyc();
    end
    idle(3);

    bus.req = 4'b1111;
    repeat (3) begin rnd_ops(); cyc(); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rnd_ops();
    cyc();
    idle(3);

    for (int n = 0; n < 400; n++) begin
      bus.req = (n % 50 < 10) ? 4'b1111 : 4'($urandom);
      rst     = ($urandom_range(0, 63) == 0);
      rnd_ops();
      cyc();
    end
    rst = 1'b0;
    idle(4);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
